// File: rtl/wb_pkg.sv
// wb_pkg: shared state type, entry type and derived-width helpers for the write-back buffer.
package wb_pkg;
    typedef enum logic {IDLE, SEND} wb_state_e;
    function automatic int offsetWidth(input int blockSize);
        return $clog2(blockSize);
    endfunction
    function automatic int tagWidth(input int addressWidth, input int blockSize);
        return addressWidth - $clog2(blockSize);
    endfunction
    function automatic int beatCount(input int blockSize, input int dataWidth);
        return blockSize * 8 / dataWidth;
    endfunction
    // Entry geometry; the top-level address/block parameters default to these values.
    localparam int ENTRY_ADDRESS_WIDTH = 32;
    localparam int ENTRY_BLOCK_SIZE = 32;
    localparam int ENTRY_TAG_WIDTH = tagWidth(ENTRY_ADDRESS_WIDTH, ENTRY_BLOCK_SIZE);
    localparam int ENTRY_DATA_WIDTH = ENTRY_BLOCK_SIZE * 8;
    typedef struct packed {
        logic [ENTRY_TAG_WIDTH-1:0] tag;
        logic [ENTRY_DATA_WIDTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/write_back_fifo.sv
// write_back_fifo: circular block store with per-entry tag/valid taps for the lookup comparators.
module write_back_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  wb_entry_t pushEntry,
    output wb_entry_t headEntry,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0][ENTRY_TAG_WIDTH-1:0] entryTags,
    output logic [DEPTH-1:0] entryValid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_entry_t store [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) store[wrPtr] <= pushEntry;
    end
    assign headEntry = store[rdPtr];
    // A slot is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
        assign entryTags[i] = store[i].tag;
        assign entryValid[i] = {1'b0, PW'(i) - rdPtr} < count;
    end
endmodule

// File: rtl/write_back_buffer.sv
// write_back_buffer: queues dirty-block evictions and drains each one to memory as a beat burst.
module write_back_buffer
    import wb_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH = ENTRY_ADDRESS_WIDTH,
    parameter int BLOCK_SIZE = ENTRY_BLOCK_SIZE,
    parameter int WB_DEPTH = 4,
    localparam int OFFSET_WIDTH = offsetWidth(BLOCK_SIZE),
    localparam int TAG_WIDTH = tagWidth(ADDRESS_WIDTH, BLOCK_SIZE),
    localparam int BEATS = beatCount(BLOCK_SIZE, DATA_WIDTH),
    localparam int CNT_WIDTH = $clog2(WB_DEPTH) + 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic [NUM_WAYS-1:0] victim_onehot,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0] way_tags,
    input  logic [BEATS*DATA_WIDTH-1:0] req_data,
    output logic mem_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic mem_last,
    input  logic mem_ack,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    output logic lookup_hit,
    output logic [CNT_WIDTH-1:0] occupancy,
    output logic waiting_for_ack,
    output logic protocol_error
);
    localparam int BEAT_WIDTH = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    wb_state_e state, stateNext;
    logic [BEAT_WIDTH-1:0] beat, beatNext;
    logic [TAG_WIDTH-1:0] victimTag;
    logic [OFFSET_WIDTH-1:0] beatOffset;
    logic victimOneHot, accept, push, pop, ackBeat, lastBeat;
    wb_entry_t headEntry;
    logic [WB_DEPTH-1:0][TAG_WIDTH-1:0] entryTags;
    logic [WB_DEPTH-1:0] entryValid;
    always_comb begin
        victimTag = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            victimTag |= victim_onehot[i] ? way_tags[i*TAG_WIDTH +: TAG_WIDTH] : '0;
    end
    assign victimOneHot = victim_onehot != '0 && (victim_onehot & (victim_onehot - 1'b1)) == '0;
    assign req_ready = occupancy != CNT_WIDTH'(WB_DEPTH);
    assign accept = req_valid && req_ready;
    assign push = accept && victimOneHot;
    assign ackBeat = state == SEND && mem_ack;
    assign lastBeat = beat == BEAT_WIDTH'(BEATS - 1);
    assign pop = ackBeat && lastBeat;
    write_back_fifo #(.DEPTH(WB_DEPTH)) fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .pop(pop),
        .pushEntry('{tag: victimTag, data: req_data}),
        .headEntry(headEntry),
        .count(occupancy),
        .entryTags(entryTags),
        .entryValid(entryValid)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            beat <= '0;
            protocol_error <= 1'b0;
        end else begin
            state <= stateNext;
            beat <= beatNext;
            protocol_error <= protocol_error || (accept && !victimOneHot);
        end
    end
    // Stay in SEND across a block boundary whenever anything is left after the pop.
    always_comb begin
        stateNext = state;
        beatNext = beat;
        if (state == IDLE) begin
            stateNext = occupancy != '0 ? SEND : IDLE;
            beatNext = '0;
        end else if (ackBeat) begin
            beatNext = lastBeat ? '0 : beat + 1'b1;
            stateNext = !lastBeat || occupancy > CNT_WIDTH'(1) || push ? SEND : IDLE;
        end
    end
    assign beatOffset = OFFSET_WIDTH'(beat) << BYTE_SHIFT;
    assign mem_valid = state == SEND;
    assign waiting_for_ack = mem_valid;
    assign mem_address = mem_valid ? {headEntry.tag, beatOffset} : '0;
    assign mem_data = mem_valid ? headEntry.data[beat*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mem_last = mem_valid && lastBeat;
    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++)
            lookup_hit |= entryValid[i] && entryTags[i] == lookup_tag;
    end
endmodule

// File: tb/tb_write_back_buffer.sv
// tb_write_back_buffer: scoreboard bench; stimulus queues expected beats, a monitor checks them.
module tb_write_back_buffer;
    localparam int TW = 27;
    localparam int BEATS = 8;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic l;
    } beat_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [3:0] victim_onehot = '0;
    logic [4*TW-1:0] way_tags = '0;
    logic [BEATS*32-1:0] req_data = '0;
    logic mem_valid;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic mem_last;
    logic mem_ack = 1'b0;
    logic [TW-1:0] lookup_tag = '0;
    logic lookup_hit;
    logic [2:0] occupancy;
    logic waiting_for_ack;
    logic protocol_error;
    int total = 0;
    int passed = 0;
    beat_t expQ[$];
    write_back_buffer dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .victim_onehot(victim_onehot),
        .way_tags(way_tags),
        .req_data(req_data),
        .mem_valid(mem_valid),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .mem_last(mem_last),
        .mem_ack(mem_ack),
        .lookup_tag(lookup_tag),
        .lookup_hit(lookup_hit),
        .occupancy(occupancy),
        .waiting_for_ack(waiting_for_ack),
        .protocol_error(protocol_error)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] beatData(input logic [7:0] seed, input int b);
        return {8'hD0, 8'h00, seed, 8'(b)};
    endfunction
    function automatic logic [31:0] beatAddr(input logic [TW-1:0] tag, input int b);
        return {tag, 5'(b * 4)};
    endfunction
    task automatic setReq(input logic [TW-1:0] tag, input int way, input logic [7:0] seed);
        way_tags[way*TW +: TW] = tag;
        victim_onehot = 4'(1 << way);
        for (int b = 0; b < BEATS; b++) req_data[b*32 +: 32] = beatData(seed, b);
    endtask
    task automatic pushExp(input logic [TW-1:0] tag, input logic [7:0] seed);
        for (int b = 0; b < BEATS; b++) expQ.push_back('{a: beatAddr(tag, b), d: beatData(seed, b), l: b == BEATS - 1});
    endtask
    task automatic enqueue(input logic [TW-1:0] tag, input int way, input logic [7:0] seed);
        setReq(tag, way, seed);
        req_valid = 1'b1;
        check("ready_before_accept", req_ready, 1);
        step();
        req_valid = 1'b0;
        pushExp(tag, seed);
    endtask
    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (expQ.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d beats left, budget %0d cycles", expQ.size(), budget);
        end
    endtask
    // Monitor: every presented beat must match the queue head; an ack retires it.
    always @(negedge clk) begin
        if (reset_n && mem_valid) begin
            if (expQ.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: address %0h with no beat expected", mem_address);
            end else begin
                check("beat_address", mem_address, expQ[0].a);
                check("beat_data", mem_data, expQ[0].d);
                check("beat_last", mem_last, expQ[0].l);
                check("waiting_for_ack", waiting_for_ack, 1);
                if (mem_ack) void'(expQ.pop_front());
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] held;
        int n;
        repeat (3) step();
        check("reset_mem_valid", mem_valid, 0);
        check("reset_req_ready", req_ready, 1);
        check("reset_occupancy", occupancy, 0);
        check("reset_protocol_error", protocol_error, 0);
        check("reset_lookup_hit", lookup_hit, 0);
        check("reset_mem_address", mem_address, 0);
        reset_n = 1'b1;
        step();
        // Single eviction, two-edge latency
        enqueue(27'h0123456, 2, 8'h11);
        check("t1_occupancy", occupancy, 1);
        check("t1_no_valid_yet", mem_valid, 0);
        step();
        check("t1_valid", mem_valid, 1);
        check("t1_first_address", mem_address, 32'h02468AC0);
        lookup_tag = 27'h0123456;
        #1 check("t1_lookup", lookup_hit, 1);
        mem_ack = 1'b1;
        waitDrain(20);
        check("t1_idle_valid", mem_valid, 0);
        check("t1_idle_address", mem_address, 0);
        check("t1_idle_data", mem_data, 0);
        check("t1_idle_last", mem_last, 0);
        check("t1_idle_occupancy", occupancy, 0);
        check("t1_idle_lookup", lookup_hit, 0);
        // Four back-to-back, ack held high
        for (int i = 0; i < 4; i++) enqueue(27'h100 + 27'(i), i, 8'h20 + 8'(i));
        check("t2_full_ready", req_ready, 0);
        check("t2_full_occupancy", occupancy, 4);
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("t2_gapless_cycles", n, 30);
        check("t2_idle_valid", mem_valid, 0);
        // Ack stall at beat 3
        mem_ack = 1'b0;
        enqueue(27'h0ABCDEF, 1, 8'h33);
        step();
        mem_ack = 1'b1;
        repeat (3) step();
        mem_ack = 1'b0;
        check("t3_beat3_address", mem_address, beatAddr(27'h0ABCDEF, 3));
        held = mem_data;
        repeat (10) step();
        check("t3_stall_address", mem_address, beatAddr(27'h0ABCDEF, 3));
        check("t3_stall_data", mem_data, held);
        mem_ack = 1'b1;
        step();
        check("t3_beat4_address", mem_address, beatAddr(27'h0ABCDEF, 4));
        waitDrain(20);
        // Full buffer, request held across the pop edge
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) enqueue(27'h300 + 27'(i), i, 8'h30 + 8'(i));
        check("t4_full_occupancy", occupancy, 4);
        setReq(27'h200, 0, 8'h40);
        req_valid = 1'b1;
        mem_ack = 1'b1;
        repeat (8) step();
        check("t4_no_bypass_occupancy", occupancy, 3);
        check("t4_ready_after_pop", req_ready, 1);
        step();
        req_valid = 1'b0;
        pushExp(27'h200, 8'h40);
        check("t4_refill_occupancy", occupancy, 4);
        waitDrain(200);
        // Lookup and protocol error
        mem_ack = 1'b0;
        enqueue(27'h0777777, 3, 8'h50);
        lookup_tag = 27'h0777777;
        #1 check("t5_lookup_hit", lookup_hit, 1);
        lookup_tag = 27'h1234567;
        #1 check("t5_lookup_miss", lookup_hit, 0);
        lookup_tag = 27'h0777777;
        mem_ack = 1'b1;
        repeat (8) step();
        check("t5_on_last_beat", mem_last, 1);
        check("t5_hit_during_last", lookup_hit, 1);
        step();
        check("t5_hit_after_pop", lookup_hit, 0);
        check("t5_idle_after_pop", mem_valid, 0);
        mem_ack = 1'b0;
        victim_onehot = 4'b0011;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("t5_protocol_error", protocol_error, 1);
        check("t5_no_enqueue", occupancy, 0);
        check("t5_ready_unaffected", req_ready, 1);
        step();
        check("t5_no_burst", mem_valid, 0);
        check("t5_error_sticky", protocol_error, 1);
        // Reset mid-burst at beat 5
        mem_ack = 1'b1;
        enqueue(27'h0555555, 2, 8'h60);
        repeat (6) step();
        mem_ack = 1'b0;
        check("t6_beat5_address", mem_address, beatAddr(27'h0555555, 5));
        #1 reset_n = 1'b0;
        #1;
        check("t6_async_valid", mem_valid, 0);
        check("t6_async_occupancy", occupancy, 0);
        check("t6_error_cleared", protocol_error, 0);
        check("t6_ready", req_ready, 1);
        expQ.delete();
        repeat (2) step();
        reset_n = 1'b1;
        mem_ack = 1'b1;
        repeat (20) step();
        check("t6_quiet_valid", mem_valid, 0);
        check("t6_quiet_occupancy", occupancy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/write_back_buffer.md
Name: write_back_buffer

Overview:
- Multi-entry, multi-beat successor to the single-entry write-back stage.
- Accepts dirty-line evictions from the cache controller and queues up to WB_DEPTH full cache blocks.
- Drains each block to main memory as a burst of DATA_WIDTH beats, using a valid/ack handshake.
- Exposes a tag-match lookup so the controller can stall a refill of a line that is still pending write-back.

Parameters:
- NUM_WAYS, 4: number of cache ways; width of the victim one-hot.
- DATA_WIDTH, 32: memory beat width in bits; must divide BLOCK_SIZE*8.
- ADDRESS_WIDTH, 32: byte address width.
- BLOCK_SIZE, 32: block size in bytes, power of 2. Derived: OFFSET_WIDTH = clog2(BLOCK_SIZE), TAG_WIDTH = ADDRESS_WIDTH-OFFSET_WIDTH, BEATS = BLOCK_SIZE*8/DATA_WIDTH.
- WB_DEPTH, 4: queued blocks, power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  eviction request
- req_ready  out  1  buffer can accept (count < WB_DEPTH)
- victim_onehot  in  NUM_WAYS  eviction target way
- way_tags  in  NUM_WAYS*TAG_WIDTH  tag of each way; way i occupies bits [i*TAG_WIDTH +: TAG_WIDTH]
- req_data  in  BEATS*DATA_WIDTH  victim block; beat 0 in the LSBs
- mem_valid  out  1  beat valid to memory
- mem_address  out  ADDRESS_WIDTH  beat byte address
- mem_data  out  DATA_WIDTH  beat data
- mem_last  out  1  final beat of the block
- mem_ack  in  1  memory accepted the current beat (already synchronised)
- lookup_tag  in  TAG_WIDTH  controller probe
- lookup_hit  out  1  probe matches a queued or in-flight block (combinational)
- occupancy  out  clog2(WB_DEPTH)+1  queued entries, including the in-flight entry
- waiting_for_ack  out  1  equals mem_valid (controller stall signal)
- protocol_error  out  1  sticky; set when victim_onehot is not one-hot on an accepted request

Behaviour:
- Reset (asynchronous): all outputs 0 except req_ready=1. Queue emptied, FSM in IDLE, protocol_error cleared. Reset during a burst abandons it immediately: mem_valid drops with no completion.
- Enqueue:
  - Fires when req_valid && req_ready at a clock edge.
  - Tag = way_tags slice selected by victim_onehot.
  - If victim_onehot is zero or multi-hot, nothing is enqueued, protocol_error is set, and req_ready is unaffected.
  - No bypass: a full buffer deasserts req_ready even if a pop occurs in the same cycle.
- Occupancy: count updates +1/-1/0 for enqueue/pop/both; simultaneous enqueue and pop leaves it unchanged.
- Drain FSM states: IDLE, SEND.
  - IDLE -> SEND when the queue is non-empty. beat=0, mem_valid registered high.
  - First mem_valid appears 2 edges after the accepting edge (minimum latency).
  - SEND: mem_valid=1. mem_address = {head_tag, beat*(DATA_WIDTH/8)} with width zero-filled. mem_data = beat slice of the head entry. mem_last = (beat==BEATS-1).
  - Outputs hold stable until mem_ack; mem_ack while mem_valid=0 is ignored.
  - On mem_ack with beat<BEATS-1: beat++ and the next beat is presented the following cycle.
  - On mem_ack with the last beat: pop the head. If another entry remains, stay in SEND with beat=0 (back-to-back, no idle cycle). Otherwise go to IDLE and clear mem_valid, mem_address, mem_data and mem_last to 0.
- Pointers: read and write pointers wrap modulo WB_DEPTH; full/empty derive from count.
- lookup_hit:
  - OR over valid entries of (entry_tag == lookup_tag), including the in-flight head until the cycle after its last ack.
  - Does not include a request being accepted in the same cycle.
- waiting_for_ack = mem_valid.

Decomposition:
- Package wb_pkg holds:
  - the wb_state_e enum (IDLE, SEND);
  - derived-width functions for OFFSET_WIDTH, TAG_WIDTH and BEATS;
  - the entry struct type {tag, data}.
- Sub-module write_back_fifo: parametrised circular storage with push/pop, count and per-entry tag/valid outputs for the lookup comparators. The top level holds the tag select, drain FSM, beat counter and error flag.

Test Plan:
- Single eviction, victim_onehot=4'b0100, way_tags[2]=0x0123456, BEATS=8 -> mem_valid high 2 edges later. Addresses 0x02468AC0..0x02468ADC step 4. mem_last only on beat 7. Returns to IDLE with outputs 0 and occupancy 0.
- Four back-to-back evictions with mem_ack held high -> req_ready=0 after the 4th accept. 32 contiguous beats with no gap between blocks. Blocks leave in FIFO order.
- mem_ack low for 10 cycles mid-burst at beat 3 -> address and data stay stable. Beat 4 follows the cycle after ack.
- Full buffer; req_valid held high while the last beat is acked -> no accept in the pop cycle. Accept on the next edge, occupancy returns to 4.
- lookup_tag equals a queued tag -> lookup_hit=1 until its final ack. Unknown tag -> 0. victim_onehot=4'b0011 -> no enqueue, protocol_error=1 until reset.
- reset_n low during beat 5 -> mem_valid=0 asynchronously, occupancy 0, no further beats after release.
